keypad_login_decoder: RTL and testbench

Consumes the merged 4-bit keypad code that the floor panels and cabin panel jointly drive, and turns it into clean key events. It synchronises and debounces the raw code, emits exactly one event per physical press, and runs the login state machine (4-digit PIN with failure lockout). Once logged in, floor-select keys become one-cycle floor request pulses for the elevator controller.

---
 rtl/keypad_login_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_login_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_login_decoder.sv
// keypad_login_decoder
//   Turns the merged, asynchronous 4-bit keypad code into clean one-shot key
//   events and runs the PIN login state machine with failure lockout. While
//   logged in, floor keys become one-cycle floor request pulses.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   keypad[3:0]  : raw merged key code, 0 = no key (asynchronous to clk)
//   key_valid    : one-cycle pulse per accepted press
//   key_code     : accepted code, held between presses
//   logged_in    : session open (UNLOCKED)
//   login_ok     : one-cycle pulse, PIN accepted
//   login_fail   : one-cycle pulse, PIN rejected
//   locked_out   : failure lockout in progress
//   digit_count  : PIN digits currently buffered (0..4)
//   floor_req    : one-hot one-cycle floor request, bit i = floor i+1
module keypad_login_decoder #(
    parameter int          DEBOUNCE    = 4,
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keypad,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       logged_in,
    output logic       login_ok,
    output logic       login_fail,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [2:0] floor_req
);

    localparam int          LW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [7:0]  STABLE_LAST = 8'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);
    localparam logic [2:0]  FAIL_LIMIT  = 3'(MAX_FAIL);

    localparam logic [3:0] K_ZERO  = 4'd10;
    localparam logic [3:0] K_CLEAR = 4'd11;
    localparam logic [3:0] K_ENTER = 4'd12;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Front end: synchroniser, stability counter, press acceptance
    // ------------------------------------------------------------------
    // sync_pipe[1] is the synchronised code s; sync_pipe[0] is the value
    // s takes at the next edge, so comparing the two tells whether s is
    // about to change.
    logic [1:0][3:0] sync_pipe;
    logic [3:0]      s;
    logic [7:0]      stable_cnt;
    logic            armed;
    logic            accept;
    logic            stable_now;

    assign s          = sync_pipe[1];
    assign stable_now = (stable_cnt == STABLE_LAST);
    assign accept     = (s != 4'd0) && stable_now && armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe  <= '0;
            stable_cnt <= 8'd0;
            armed      <= 1'b1;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            sync_pipe <= {sync_pipe[0], keypad};

            if (sync_pipe[0] != sync_pipe[1])
                stable_cnt <= 8'd0;
            else if (stable_cnt != 8'hFF)
                stable_cnt <= stable_cnt + 8'd1;

            // Re-arming needs a debounced release, so a direct change
            // between two nonzero codes never yields a second event.
            if (accept)
                armed <= 1'b0;
            else if ((s == 4'd0) && stable_now)
                armed <= 1'b1;

            key_valid <= accept;
            if (accept)
                key_code <= s;
        end
    end

    // ------------------------------------------------------------------
    // Login FSM, driven by the registered key events
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [15:0]   pin_buf, pin_buf_n;
    logic [2:0]    digit_n;
    logic [2:0]    fail_cnt, fail_cnt_n;
    logic [LW-1:0] lock_cnt, lock_cnt_n;
    logic          login_ok_n, login_fail_n;
    logic [2:0]    floor_n;
    logic          is_digit;
    logic [3:0]    digit_val;

    assign is_digit  = (key_code >= 4'd1) && (key_code <= K_ZERO);
    assign digit_val = (key_code == K_ZERO) ? 4'd0 : key_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOCKED;
            pin_buf     <= 16'd0;
            digit_count <= 3'd0;
            fail_cnt    <= 3'd0;
            lock_cnt    <= '0;
            login_ok    <= 1'b0;
            login_fail  <= 1'b0;
            floor_req   <= 3'd0;
        end else begin
            state       <= state_n;
            pin_buf     <= pin_buf_n;
            digit_count <= digit_n;
            fail_cnt    <= fail_cnt_n;
            lock_cnt    <= lock_cnt_n;
            login_ok    <= login_ok_n;
            login_fail  <= login_fail_n;
            floor_req   <= floor_n;
        end
    end

    always_comb begin
        state_n      = state;
        pin_buf_n    = pin_buf;
        digit_n      = digit_count;
        fail_cnt_n   = fail_cnt;
        lock_cnt_n   = lock_cnt;
        login_ok_n   = 1'b0;
        login_fail_n = 1'b0;
        floor_n      = 3'd0;

        case (state)
            ST_LOCKED: begin
                if (key_valid) begin
                    if (is_digit) begin
                        // A fifth and later digit is dropped, not shifted in.
                        if (digit_count < 3'd4) begin
                            pin_buf_n = {pin_buf[11:0], digit_val};
                            digit_n   = digit_count + 3'd1;
                        end
                    end else if (key_code == K_CLEAR) begin
                        pin_buf_n = 16'd0;
                        digit_n   = 3'd0;
                    end else if (key_code == K_ENTER) begin
                        pin_buf_n = 16'd0;
                        digit_n   = 3'd0;
                        if ((digit_count == 3'd4) && (pin_buf == PASSWORD)) begin
                            state_n    = ST_UNLOCKED;
                            login_ok_n = 1'b1;
                            fail_cnt_n = 3'd0;
                        end else begin
                            login_fail_n = 1'b1;
                            fail_cnt_n   = fail_cnt + 3'd1;
                            if ((fail_cnt + 3'd1) == FAIL_LIMIT) begin
                                state_n    = ST_LOCKOUT;
                                lock_cnt_n = LOCK_LOAD;
                            end
                        end
                    end
                end
            end

            ST_UNLOCKED: begin
                if (key_valid) begin
                    case (key_code)
                        4'd13:   floor_n = 3'b001;
                        4'd14:   floor_n = 3'b010;
                        4'd15:   floor_n = 3'b100;
                        K_CLEAR: state_n = ST_LOCKED;
                        default: ;
                    endcase
                end
            end

            ST_LOCKOUT: begin
                // Events are dropped here, including one arriving in the
                // final cycle while the exit transition is taken.
                if (lock_cnt == '0) begin
                    state_n    = ST_LOCKED;
                    fail_cnt_n = 3'd0;
                end else begin
                    lock_cnt_n = lock_cnt - LW'(1);
                end
            end

            default: state_n = ST_LOCKED;
        endcase
    end

    assign logged_in  = (state == ST_UNLOCKED);
    assign locked_out = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_keypad_login_decoder.sv
module tb_keypad_login_decoder;

    localparam int          DEB   = 4;
    localparam int          MAXF  = 3;
    localparam int          LOCKC = 10;
    localparam logic [15:0] PIN   = 16'h1234;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keypad = 4'd0;
    logic       key_valid, logged_in, login_ok, login_fail, locked_out;
    logic [3:0] key_code;
    logic [2:0] digit_count, floor_req;

    always #5 clk = ~clk;

    keypad_login_decoder #(
        .DEBOUNCE(DEB), .PASSWORD(PIN), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keypad(keypad),
        .key_valid(key_valid), .key_code(key_code),
        .logged_in(logged_in), .login_ok(login_ok), .login_fail(login_fail),
        .locked_out(locked_out), .digit_count(digit_count), .floor_req(floor_req)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Press detection: a press of v is seen when the sampled keypad has
    // shown v for DEBOUNCE consecutive samples and a debounced release was
    // seen since the previous press; it is reported two edges later.
    // Login: digits kept in a queue, lockout tracked as an end step number.
    int         step_n;
    logic [3:0] last_k;
    int         run;
    bit         armed;
    bit         d1_v, d2_v;
    logic [3:0] d1_c, d2_c;
    bit         e_kv, p_kv;
    logic [3:0] e_code, p_code;
    int         mode;           // 0 locked, 1 unlocked, 2 lockout
    int         pin_q[$];
    int         fails;
    int         lock_until;
    bit         e_ok, e_fail;
    logic [2:0] e_floor;

    task automatic model_reset();
        step_n = 0; last_k = 4'd0; run = 1; armed = 1'b1;
        d1_v = 0; d2_v = 0; d1_c = 4'd0; d2_c = 4'd0;
        e_kv = 0; p_kv = 0; e_code = 4'd0; p_code = 4'd0;
        mode = 0; pin_q.delete(); fails = 0; lock_until = 0;
        e_ok = 0; e_fail = 0; e_floor = 3'd0;
    endtask

    task automatic model_step(input logic [3:0] k);
        bit dec;
        int v;
        step_n++;
        e_ok = 0; e_fail = 0; e_floor = 3'd0;
        if (mode == 2) begin
            if (step_n >= lock_until) begin
                mode = 0;
                fails = 0;
            end
        end else if (p_kv) begin
            if (mode == 0) begin
                if (p_code >= 1 && p_code <= 10) begin
                    if (pin_q.size() < 4) pin_q.push_back((p_code == 10) ? 0 : int'(p_code));
                end else if (p_code == 11) begin
                    pin_q.delete();
                end else if (p_code == 12) begin
                    v = -1;
                    if (pin_q.size() == 4)
                        v = pin_q[0] * 4096 + pin_q[1] * 256 + pin_q[2] * 16 + pin_q[3];
                    pin_q.delete();
                    if (v == int'(PIN)) begin
                        e_ok = 1; mode = 1; fails = 0;
                    end else begin
                        e_fail = 1; fails++;
                        if (fails == MAXF) begin
                            mode = 2;
                            lock_until = step_n + LOCKC;
                        end
                    end
                end
            end else begin
                if (p_code >= 13) e_floor = 3'(1 << (p_code - 13));
                else if (p_code == 11) mode = 0;
            end
        end

        if (k == last_k) run++;
        else begin run = 1; last_k = k; end
        dec = 0;
        if (run == DEB) begin
            if (k == 4'd0) armed = 1;
            else if (armed) begin dec = 1; armed = 0; end
        end
        e_kv = d2_v;
        if (d2_v) e_code = d2_c;
        d2_v = d1_v; d2_c = d1_c;
        d1_v = dec;  d1_c = k;
        p_kv = e_kv; p_code = e_code;
    endtask

    function automatic logic [14:0] outs_dut();
        return {key_valid, key_code, login_ok, login_fail, logged_in, locked_out,
                digit_count, floor_req};
    endfunction

    function automatic logic [14:0] outs_exp();
        return {e_kv, e_code, e_ok, e_fail, (mode == 1), (mode == 2),
                3'(pin_q.size()), e_floor};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [3:0] k);
        keypad = k;
        @(posedge clk);
        #1;
        model_step(k);
        chk($sformatf("outs@%0d", step_n), 32'(outs_dut()), 32'(outs_exp()));
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int rel);
        repeat (hold) cyc(v);
        repeat (rel) cyc(4'd0);
    endtask

    task automatic key(input logic [3:0] v);
        press(v, $urandom_range(DEB + 6, DEB), $urandom_range(DEB + 5, DEB + 1));
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] d;
            d = p[i*4 +: 4];
            key((d == 4'd0) ? 4'd10 : d);
        end
        key(4'd12);
    endtask

    task automatic do_reset(input string tag);
        keypad = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk(tag, 32'(outs_dut()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] rv;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs_dut()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cyc(4'd0);

        // held key: one event, digit buffered
        press(4'd5, 50, 10);
        key(4'd11);

        // bounce faster than the debounce window, then a clean hold
        for (int i = 0; i < 5; i++) begin
            cyc(4'd5); cyc(4'd5); cyc(4'd0); cyc(4'd0);
        end
        press(4'd5, 12, 8);
        // nonzero to nonzero without release
        press(4'd5, 10, 0);
        press(4'd7, 10, 8);
        key(4'd11);

        // login, floor request, logout
        enter_pin(PIN);
        key(4'd14);
        key(4'd13);
        key(4'd3);
        key(4'd15);
        key(4'd11);

        // rejected logins, overflowed buffer, floor while locked
        key(4'd1); key(4'd2); key(4'd3); key(4'd12);
        enter_pin(16'h1235);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd6); key(4'd12);
        key(4'd11);
        key(4'd13);

        // lockout, PIN during lockout, then successful login
        enter_pin(16'h0000); enter_pin(16'h9999); key(4'd12);
        enter_pin(PIN);
        repeat (20) cyc(4'd0);
        enter_pin(PIN);
        key(4'd11);

        // lockout entries with varied key timing around the exit cycle
        for (int j = 0; j < 8; j++) begin
            key(4'd12); key(4'd12);
            press(4'd12, DEB + 1, DEB + j % 4);
            key(4'd1);
            key(4'd12);
            repeat (12) cyc(4'd0);
        end

        // reset mid-lockout, while unlocked, and after partial failures
        key(4'd12); key(4'd12); key(4'd12);
        repeat (3) cyc(4'd0);
        do_reset("rst_in_lockout");
        repeat (8) cyc(4'd0);
        enter_pin(PIN);
        do_reset("rst_in_unlocked");
        repeat (8) cyc(4'd0);
        key(4'd12); key(4'd12);
        do_reset("rst_after_fails");
        repeat (8) cyc(4'd0);
        key(4'd12); key(4'd12);
        enter_pin(PIN);
        key(4'd11);

        // random presses, bounces and direct changes
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                key(4'd11);
                enter_pin(PIN);
                key(4'($urandom_range(15, 13)));
                key(4'd11);
            end
            rv = 4'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) rv = 4'd12;
            press(rv, $urandom_range(DEB + 6, 1), $urandom_range(DEB + 5, 0));
        end
        repeat (20) cyc(4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
